fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the instruction decoder. It owns the program counter, fetches one 32-bit instruction at a time over a request/acknowledge instruction-memory port, and presents it with its PC to the decode stage. It then waits for the execute stage to retire that instruction, computes the next PC (sequential or PC-relative branch), and fetches again. The design is strictly non-pipelined: at most one instruction is in flight.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch stage: owns the PC, fetches one word over a
// req/ack port, holds it for decode until retired, then steps or branches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    input  logic        retire,
    input  logic        taken,
    input  logic [1:0]  pc_mode,
    input  logic [31:0] pc_update,
    input  logic        halt,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_HOLD,
        S_HALTED,
        S_FAULT
    } state_t;

    localparam logic [1:0] MODE_ADD = 2'd1;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] instret_q, instret_d;
    logic        req_q, valid_q, halted_q, fault_q;
    logic [31:0] next_pc;

    // Offset is two's complement, so a plain modulo-2^32 add covers both directions.
    function automatic logic [31:0] pc_target(input logic [31:0] base, input logic [1:0] mode,
                                              input logic tk, input logic [31:0] off);
        logic signed [31:0] soff;
        soff = off;
        if (tk && (mode == MODE_ADD)) begin
            return base + $unsigned(soff);
        end
        return base + 32'd4;
    endfunction

    assign next_pc = pc_target(inst_pc_q, pc_mode, taken, pc_update);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        instret_d = instret_q;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    if (imem_err) begin
                        state_d = S_FAULT;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (retire) begin
                    instret_d = instret_q + 32'd1;
                    // PC takes the target even on halt or misalignment, for debug visibility.
                    pc_d = next_pc;
                    if (halt) begin
                        state_d = S_HALTED;
                    end else if (next_pc[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_START;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            instret_q <= 32'd0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            instret_q <= instret_d;
            req_q     <= (state_d == S_FETCH);
            valid_q   <= (state_d == S_HOLD);
            halted_q  <= (state_d == S_HALTED);
            fault_q   <= (state_d == S_FAULT);
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign inst_pc    = inst_pc_q;
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign instret    = instret_q;

endmodule
